register_file: RTL and testbench
================================

Name: register_file

Overview:
Parametrised multi-entry register bank. It generalises the single 16-bit load-enabled register to DEPTH words of WIDTH bits, with one write port, two independent read ports, a bulk clear and per-entry written-flags. It is the storage building block for the RAM8/RAM64 hierarchy and for CPU scratch-register experiments in the Hardware Platform tree.

Parameters:
WIDTH, 16, bits per word.
DEPTH, 8, number of words; any value ≥2, not required to be a power of two.
ADDR_W, $clog2(DEPTH), address width; derived, not overridden.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
D  in  WIDTH  write data.
load  in  1  write enable, sampled at the rising CLK edge.
waddr  in  ADDR_W  write address.
clear  in  1  synchronous clear of all entries.
raddr_a  in  ADDR_W  read address, port A.
raddr_b  in  ADDR_W  read address, port B.
Q_a  out  WIDTH  read data, port A.
Q_b  out  WIDTH  read data, port B.
written  out  DEPTH  bit i = 1 if entry i has been written since the last reset or clear.

Behaviour:
- Reset (reset_n=0): all entries become 0 and written becomes 0 immediately, regardless of CLK. While reset is held, Q_a and Q_b read 0. On deassertion, the first write can occur at the next rising edge. Reset asserted mid-sequence discards all contents.
- Write: at a rising edge with load=1, clear=0 and waddr<DEPTH, mem[waddr]<=D and written[waddr]<=1. With load=0, every entry holds its value, as the single register does.
- Clear: at a rising edge with clear=1, all entries <=0 and written<=0. Clear takes priority over a simultaneous load, so the load is discarded.
- Read: combinational, with zero latency in the same cycle. Q_a=mem[raddr_a] and Q_b=mem[raddr_b]. Both ports may address the same entry.
- Read-during-write (default build): a read of waddr while load=1 returns the old contents until the edge and the new value after it. That is one-cycle write-to-read latency.
- Out-of-range address (only when DEPTH is not a power of two): a write to waddr≥DEPTH is ignored with no state change; a read of raddr≥DEPTH returns 0.
- Writing an entry repeatedly keeps its written bit at 1. Writing data of 0 still sets the written bit.
- No internal FSM beyond the storage. The written vector is the only state besides the data array.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-through forwarding. If load=1, clear=0, waddr<DEPTH and raddr_x==waddr, then Q_x=D combinationally in the same cycle. Forwarding is suppressed when clear=1; in that case Q_x shows the old contents.
- Undefined: no forwarding. Read-during-write returns old data as described above.

Test Plan:
1. Reset: hold reset_n=0 across 2 edges with load=1 and D=16'hFFFF → all reads 0 and written=8'h00. Release reset, then write 16'hAAAA to addr 3 → Q_a(raddr_a=3)=16'hAAAA after the edge and written=8'h08.
2. Hold/dual read: write 16'hBBBB to addr 0 and 16'hCCCC to addr 7, then load=0 for 3 edges with D=16'h1234 → Q_a(0)=16'hBBBB and Q_b(7)=16'hCCCC unchanged. Both ports at addr 7 → both read 16'hCCCC.
3. Clear priority: at one edge set clear=1, load=1, waddr=2, D=16'hEEEE → every entry reads 0, written=0, and entry 2 is not written.
4. Read-during-write: addr 5 holds 16'h1111; set load=1, waddr=5, D=16'h2222, raddr_a=5 → before the edge Q_a=16'h1111 (bypass undefined) or 16'h2222 (REGFILE_BYPASS_EN); after the edge Q_a=16'h2222 in both builds.
5. Non-power-of-two: DEPTH=6, write 16'hDEAD to waddr=6 → no entry changes, written unchanged, and raddr_a=7 reads 0.
6. Async reset mid-operation: drop reset_n between edges after filling all entries → Q_a and Q_b go to 0 before the next CLK edge and written=0.

Source files
------------

// File: rtl/register_file.sv
// Parametrised register bank: one write port, two combinational read ports,
// synchronous bulk clear and per-entry written flags. Optional macro REGFILE_BYPASS_EN adds write-through forwarding.
module register_file #(
   parameter  int WIDTH  = 16,
   parameter  int DEPTH  = 8,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              CLK,
   input  logic              reset_n,
   input  logic [WIDTH-1:0]  D,
   input  logic              load,
   input  logic [ADDR_W-1:0] waddr,
   input  logic              clear,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [WIDTH-1:0]  Q_a,
   output logic [WIDTH-1:0]  Q_b,
   output logic [DEPTH-1:0]  written
);

   localparam logic [31:0] DEPTH_L = DEPTH;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] written_q;
   logic             wa_ok;
   logic             ra_ok;
   logic             rb_ok;
   logic             wr_en;

   // Addresses at or above DEPTH only exist when DEPTH is not a power of two
   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      logic [31:0] a_ext;
      a_ext = 32'(a);
      return a_ext < DEPTH_L;
   endfunction

   assign wa_ok = in_range(waddr);
   assign ra_ok = in_range(raddr_a);
   assign rb_ok = in_range(raddr_b);
   assign wr_en = load & ~clear & wa_ok;

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         written_q <= '0;
      end else if (clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         written_q <= '0;
      end else if (wr_en) begin
         mem[waddr]       <= D;
         written_q[waddr] <= 1'b1;
      end
   end

   always_comb begin
      Q_a = ra_ok ? mem[raddr_a] : '0;
      Q_b = rb_ok ? mem[raddr_b] : '0;
`ifdef REGFILE_BYPASS_EN
      // Forwarding is held off during reset so reads stay zero while it is asserted
      if (reset_n && wr_en && (raddr_a == waddr)) begin
         Q_a = D;
      end
      if (reset_n && wr_en && (raddr_b == waddr)) begin
         Q_b = D;
      end
`endif
   end

   assign written = written_q;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: a DEPTH=8 instance and a DEPTH=6 instance
// for the out-of-range cases; expectations are queued and checked on the falling edge.
module tb_register_file;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        rst_n;

   logic [15:0] d8;
   logic        load8, clear8;
   logic [2:0]  waddr8, ra8, rb8;
   logic [15:0] qa8, qb8;
   logic [7:0]  w8;

   logic [15:0] d6;
   logic        load6, clear6;
   logic [2:0]  waddr6, ra6, rb6;
   logic [15:0] qa6, qb6;
   logic [5:0]  w6;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       name;
      bit          which;
      logic [15:0] qa;
      logic [15:0] qb;
      logic [7:0]  w;
   } exp_t;

   exp_t sb[$];

   register_file #(.WIDTH(16), .DEPTH(8)) dut8 (
      .CLK(clk), .reset_n(rst_n), .D(d8), .load(load8), .waddr(waddr8),
      .clear(clear8), .raddr_a(ra8), .raddr_b(rb8),
      .Q_a(qa8), .Q_b(qb8), .written(w8)
   );

   register_file #(.WIDTH(16), .DEPTH(6)) dut6 (
      .CLK(clk), .reset_n(rst_n), .D(d6), .load(load6), .waddr(waddr6),
      .clear(clear6), .raddr_a(ra6), .raddr_b(rb6),
      .Q_a(qa6), .Q_b(qb6), .written(w6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every queued expectation is compared against the DUT at the falling edge
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         exp_t        e;
         logic [15:0] a_act, b_act;
         logic [7:0]  w_act;
         e = sb.pop_front();
         a_act = e.which ? qa6 : qa8;
         b_act = e.which ? qb6 : qb8;
         w_act = e.which ? {2'b00, w6} : w8;
         checks += 3;
         if (a_act !== e.qa) begin
            failures++;
            $display("FAIL %s Q_a: got %h expected %h", e.name, a_act, e.qa);
         end
         if (b_act !== e.qb) begin
            failures++;
            $display("FAIL %s Q_b: got %h expected %h", e.name, b_act, e.qb);
         end
         if (w_act !== e.w) begin
            failures++;
            $display("FAIL %s written: got %h expected %h", e.name, w_act, e.w);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect8(input string name, input logic [15:0] qa,
                          input logic [15:0] qb, input logic [7:0] w);
      exp_t e;
      e.name = name; e.which = 1'b0; e.qa = qa; e.qb = qb; e.w = w;
      sb.push_back(e);
   endtask

   task automatic expect6(input string name, input logic [15:0] qa,
                          input logic [15:0] qb, input logic [7:0] w);
      exp_t e;
      e.name = name; e.which = 1'b1; e.qa = qa; e.qb = qb; e.w = w;
      sb.push_back(e);
   endtask

   initial begin
      rst_n = 1'b0;
      d8 = 16'hFFFF; load8 = 1'b1; clear8 = 1'b0; waddr8 = 3'd3; ra8 = 3'd3; rb8 = 3'd0;
      d6 = 16'hFFFF; load6 = 1'b1; clear6 = 1'b0; waddr6 = 3'd1; ra6 = 3'd1; rb6 = 3'd0;

      // Reset held across two edges with load active
      step();
      step();
      expect8("rst_hold", 16'h0000, 16'h0000, 8'h00);
      expect6("rst_hold6", 16'h0000, 16'h0000, 8'h00);

      step();
      rst_n = 1'b1;
      d8 = 16'hAAAA; load8 = 1'b1; waddr8 = 3'd3; ra8 = 3'd3; rb8 = 3'd0;
      load6 = 1'b0;
      expect8("pre_wr3", BYP ? 16'hAAAA : 16'h0000, 16'h0000, 8'h00);
      step();
      load8 = 1'b0;
      expect8("post_wr3", 16'hAAAA, 16'h0000, 8'h08);

      // Two writes then three idle edges with new D
      step(); load8 = 1'b1; waddr8 = 3'd0; d8 = 16'hBBBB;
      step(); waddr8 = 3'd7; d8 = 16'hCCCC;
      step(); load8 = 1'b0; waddr8 = 3'd1; d8 = 16'h1234;
      step(); step(); step();
      ra8 = 3'd0; rb8 = 3'd7;
      expect8("hold_dual", 16'hBBBB, 16'hCCCC, 8'h89);
      step();
      ra8 = 3'd7; rb8 = 3'd7;
      expect8("same_addr", 16'hCCCC, 16'hCCCC, 8'h89);

      // Zero data still marks written; rewrite keeps bit set
      step(); load8 = 1'b1; waddr8 = 3'd1; d8 = 16'h0000;
      step(); waddr8 = 3'd3; d8 = 16'h5555;
      step(); load8 = 1'b0;
      ra8 = 3'd1; rb8 = 3'd3;
      expect8("zero_rewrite", 16'h0000, 16'h5555, 8'h8B);

      // Clear beats a simultaneous load
      step();
      clear8 = 1'b1; load8 = 1'b1; waddr8 = 3'd2; d8 = 16'hEEEE; ra8 = 3'd2; rb8 = 3'd7;
      expect8("pre_clear", 16'h0000, 16'hCCCC, 8'h8B);
      step();
      clear8 = 1'b0; load8 = 1'b0;
      expect8("post_clear", 16'h0000, 16'h0000, 8'h00);
      ra8 = 3'd3; rb8 = 3'd0;
      expect8("post_clear2", 16'h0000, 16'h0000, 8'h00);

      // Read-during-write on entry 5
      step(); load8 = 1'b1; waddr8 = 3'd5; d8 = 16'h1111;
      step(); load8 = 1'b0;
      ra8 = 3'd5; rb8 = 3'd4;
      expect8("wr5", 16'h1111, 16'h0000, 8'h20);
      step();
      load8 = 1'b1; waddr8 = 3'd5; d8 = 16'h2222; ra8 = 3'd5; rb8 = 3'd4;
      expect8("rdw_pre", BYP ? 16'h2222 : 16'h1111, 16'h0000, 8'h20);
      step();
      load8 = 1'b0;
      expect8("rdw_post", 16'h2222, 16'h0000, 8'h20);

      // Non-power-of-two depth: addresses 6 and 7 do not exist
      step(); load6 = 1'b1; waddr6 = 3'd4; d6 = 16'h4444;
      step();
      load6 = 1'b1; waddr6 = 3'd6; d6 = 16'hDEAD; ra6 = 3'd7; rb6 = 3'd4;
      expect6("oor_pre", 16'h0000, 16'h4444, 8'h10);
      step();
      waddr6 = 3'd7; d6 = 16'hBEEF; ra6 = 3'd6;
      expect6("oor_w6", 16'h0000, 16'h4444, 8'h10);
      step();
      load6 = 1'b1; waddr6 = 3'd5; d6 = 16'h5A5A; ra6 = 3'd7; rb6 = 3'd6;
      expect6("oor_w7", 16'h0000, 16'h0000, 8'h10);
      step();
      load6 = 1'b0; ra6 = 3'd5; rb6 = 3'd4;
      expect6("last_entry", 16'h5A5A, 16'h4444, 8'h30);

      // Fill every entry, then async reset between edges
      for (int i = 0; i < 8; i++) begin
         step(); load8 = 1'b1; waddr8 = 3'(i); d8 = 16'h1000 + 16'(i);
      end
      step(); load8 = 1'b0;
      ra8 = 3'd6; rb8 = 3'd2;
      expect8("filled", 16'h1006, 16'h1002, 8'hFF);
      step();
      #2;
      rst_n = 1'b0;
      expect8("async_rst", 16'h0000, 16'h0000, 8'h00);
      expect6("async_rst6", 16'h0000, 16'h0000, 8'h00);
      step();
      rst_n = 1'b1;
      ra8 = 3'd7; rb8 = 3'd0;
      expect8("after_rst", 16'h0000, 16'h0000, 8'h00);

      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
